// File: rtl/seg_display.sv
// rtl/seg_display.sv - 4-digit hex scanner with frame snapshot and single-step key conditioning.
// Optional macro SEG_DISPLAY_DEBOUNCE_EN enables the DEB_CYCLES key debounce filter.
module seg_display #(
  parameter int SCAN_DIV   = 100000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [1:0]  sel,
  input  logic [31:0] pc,
  input  logic [31:0] newpc,
  input  logic [4:0]  rs,
  input  logic [31:0] ReadData1,
  input  logic [4:0]  rt,
  input  logic [31:0] ReadData2,
  input  logic [31:0] ALUResult,
  input  logic [31:0] RegWriteData,
  input  logic        step_key,
  output logic        step_pulse,
  output logic [3:0]  pos_ctrl,
  output logic [7:0]  num_ctrl
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [15:0]   snapshot;
  logic [15:0]   frame;
  logic [3:0]    nibble;
  logic [6:0]    seg;
  logic          scan_tc;

  logic unused_bits;
  assign unused_bits = ^{pc[31:8], newpc[31:8], ReadData1[31:8], ReadData2[31:8],
                         ALUResult[31:8], RegWriteData[31:8]};

  always_comb begin
    frame = 16'h0000;
    case (sel)
      2'b00:   frame = {pc[7:0], newpc[7:0]};
      2'b01:   frame = {3'b000, rs, ReadData1[7:0]};
      2'b10:   frame = {3'b000, rt, ReadData2[7:0]};
      default: frame = {ALUResult[7:0], RegWriteData[7:0]};
    endcase
  end

  assign scan_tc = (scan_cnt == SCAN_LAST);

  // Snapshot only on the 3 -> 0 wrap so a lit frame never mixes two sources.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      snapshot <= 16'h0000;
    end else if (scan_tc) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
      if (idx == 2'd3)
        snapshot <= frame;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  assign nibble = snapshot[4*idx +: 4];

  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      pos_ctrl <= 4'b1111;
      num_ctrl <= 8'hFF;
    end else begin
      pos_ctrl <= ~(4'b0001 << idx);
      num_ctrl <= {1'b1, seg};
    end
  end

  logic sync1, sync2, filt, accept;

`ifdef SEG_DISPLAY_DEBOUNCE_EN
  localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  logic [DW-1:0] deb_cnt;

  assign accept = (sync2 != filt) && (deb_cnt == DEB_LAST);

  // Any sample that agrees with the filtered level restarts the stability count.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST)
      deb_cnt <= '0;
    else if (sync2 == filt || accept)
      deb_cnt <= '0;
    else
      deb_cnt <= deb_cnt + DW'(1);
  end
`else
  assign accept = (sync2 != filt);
`endif

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      filt       <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      sync1      <= step_key;
      sync2      <= sync1;
      if (accept)
        filt <= sync2;
      step_pulse <= accept & sync2;
    end
  end

endmodule
